pipelined_fetch_stage: RTL and testbench
========================================

Name: pipelined_fetch_stage

Overview:
Instruction-fetch stage for the next-generation pipelined MIPS datapath. It replaces the single-cycle PC / PC+4 / branch-mux path with these parts:
- a parametrised PC register;
- stall, flush and redirect control from later stages;
- an IF/ID pipeline register;
- a fetch performance counter.

It drives the combinational InstructionMemory address and registers the returned instruction for the decode stage.

Parameters:
ADDR_WIDTH, 32, width of PC, targets and PC+step values
INSTR_WIDTH, 32, instruction word width
RESET_VECTOR, 0, PC value after reset (must be PC_STEP-aligned)
PC_STEP, 4, byte increment per fetch (power of two)
CNT_WIDTH, 16, width of fetch counter

Ports:
Clk  in  1  rising-edge clock
Rst  in  1  asynchronous, active-low reset
Stall  in  1  hazard unit: hold PC and IF/ID
Flush  in  1  insert bubble into IF/ID
BranchTaken  in  1  redirect from EX (resolved branch)
BranchTarget  in  ADDR_WIDTH  branch destination
JumpTaken  in  1  redirect from ID (j/jal/jr)
JumpTarget  in  ADDR_WIDTH  jump destination
IM_Address  out  ADDR_WIDTH  address to InstructionMemory (= current PC)
IM_Instruction  in  INSTR_WIDTH  instruction returned combinationally for IM_Address
IF_ID_Instruction  out  INSTR_WIDTH  registered instruction
IF_ID_PCPlus  out  ADDR_WIDTH  registered PC+PC_STEP of that instruction
IF_ID_Valid  out  1  1 = real instruction, 0 = bubble
AlignErr  out  1  registered one-cycle pulse: redirect target misaligned
FetchCount  out  CNT_WIDTH  count of valid instructions entered into IF/ID

Behaviour:
Reset (Rst=0, asynchronous, regardless of Clk):
- PC=RESET_VECTOR.
- IF_ID_Instruction=0 (nop), IF_ID_PCPlus=0, IF_ID_Valid=0.
- AlignErr=0, FetchCount=0.
- First fetch occurs on the first rising edge after Rst deasserts.

IM_Address equals PC combinationally. The instruction appears in IF/ID one cycle after its address is presented.

PC next-state priority, evaluated per rising edge, highest first:
1. BranchTaken: PC <= BranchTarget with low log2(PC_STEP) bits cleared.
2. JumpTaken: PC <= JumpTarget, low bits cleared.
3. Stall: PC holds.
4. Otherwise: PC <= PC+PC_STEP, modulo 2^ADDR_WIDTH. All-ones-aligned PC wraps to 0 with no error.

Redirect rules:
- BranchTaken beats JumpTaken when both are asserted, because the branch is older.
- Any redirect overrides Stall.

IF/ID next-state priority, highest first:
1. BranchTaken, JumpTaken or Flush: load bubble (Instruction=0, PCPlus=0, Valid=0).
2. Stall: hold all IF/ID fields.
3. Otherwise: Instruction <= IM_Instruction, PCPlus <= PC+PC_STEP, Valid <= 1.

Flush combined with Stall and no redirect: IF/ID becomes a bubble while PC still holds.

AlignErr:
- Set for exactly one cycle after the edge where the selected redirect target had any nonzero low log2(PC_STEP) bit.
- Only the winning redirect's target is checked.

FetchCount:
- Increments by 1 on each edge where IF/ID loads with Valid=1.
- Saturates at all-ones; never wraps.

No other state exists. The stage never blocks; the caller guarantees IM_Instruction is valid in the same cycle.

Test Plan:
1. Reset and run: Rst low 2 cycles then high, no controls, defaults → IM_Address sequence 0,4,8,12. IF_ID_Instruction tracks each fetched word one cycle later. IF_ID_PCPlus 4,8,12. Valid=1 from the first edge. FetchCount=3 after 3 edges.
2. Stall: Stall high 2 cycles while PC=0x10 → PC stays 0x10 and IF/ID holds the word at 0x0C for both cycles. FetchCount does not change. On release, PC=0x14 next edge.
3. Branch vs jump vs stall: BranchTaken=1 with BranchTarget=0x40, JumpTaken=1 with JumpTarget=0x80, Stall=1, all in the same cycle → PC=0x40 and IF_ID_Valid=0. The next edge loads the word at 0x40 with PCPlus=0x44.
4. Misaligned jump: JumpTaken=1, JumpTarget=0x103 → PC=0x100 and AlignErr=1 for exactly one cycle, then 0.
5. Wrap and saturation: RESET_VECTOR=0xFFFFFFF8, CNT_WIDTH=2, run 5 cycles → PC sequence FFFFFFF8, FFFFFFFC, 0, 4. FetchCount reads 1,2,3,3.
6. Async reset mid-run: drop Rst between clock edges at PC=0x24 → all outputs reset immediately without a clock edge, and PC=RESET_VECTOR.

Source files
------------

// File: rtl/pipelined_fetch_stage.sv
// Instruction fetch: PC register, redirect/stall/flush control, IF/ID register, fetch counter.
// Latency: IM_Address is combinational from PC; the fetched word lands in IF/ID one edge later.
// Backpressure: Stall holds PC and IF/ID; redirects and Flush override it; the stage never blocks.
module pipelined_fetch_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int PC_STEP = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Stall,
    input  logic                   Flush,
    input  logic                   BranchTaken,
    input  logic [ADDR_WIDTH-1:0]  BranchTarget,
    input  logic                   JumpTaken,
    input  logic [ADDR_WIDTH-1:0]  JumpTarget,
    output logic [ADDR_WIDTH-1:0]  IM_Address,
    input  logic [INSTR_WIDTH-1:0] IM_Instruction,
    output logic [INSTR_WIDTH-1:0] IF_ID_Instruction,
    output logic [ADDR_WIDTH-1:0]  IF_ID_PCPlus,
    output logic                   IF_ID_Valid,
    output logic                   AlignErr,
    output logic [CNT_WIDTH-1:0]   FetchCount
);

    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(PC_STEP - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(PC_STEP);

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc_plus;
        logic                   vld;
    } ifid_t;

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus;
    logic [ADDR_WIDTH-1:0] redirect_tgt;
    logic                  redirect;
    logic                  load_vld;
    ifid_t                 ifid;

    // The branch comes from EX and is older than a jump in ID, so it wins.
    assign redirect     = BranchTaken | JumpTaken;
    assign redirect_tgt = BranchTaken ? BranchTarget : JumpTarget;
    assign pc_plus      = pc + STEP;
    assign load_vld     = !redirect && !Flush && !Stall;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pc <= RESET_VECTOR;
        end else if (redirect) begin
            pc <= redirect_tgt & ~LOW_MASK;
        end else if (!Stall) begin
            pc <= pc_plus;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ifid <= '0;
        end else if (redirect || Flush) begin
            ifid <= '0;
        end else if (!Stall) begin
            ifid.instr   <= IM_Instruction;
            ifid.pc_plus <= pc_plus;
            ifid.vld     <= 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            AlignErr <= 1'b0;
        end else begin
            AlignErr <= redirect && |(redirect_tgt & LOW_MASK);
        end
    end

    // Saturating: a pegged counter is more useful to software than a wrapped one.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            FetchCount <= '0;
        end else if (load_vld && (FetchCount != {CNT_WIDTH{1'b1}})) begin
            FetchCount <= FetchCount + CNT_WIDTH'(1);
        end
    end

    assign IM_Address        = pc;
    assign IF_ID_Instruction = ifid.instr;
    assign IF_ID_PCPlus      = ifid.pc_plus;
    assign IF_ID_Valid       = ifid.vld;

endmodule

// File: tb/tb_pipelined_fetch_stage.sv
// Directed plus randomized bench for pipelined_fetch_stage, checked against a cycle-level reference model.
// A second instance covers PC wrap at the top of the address space and counter saturation.
module tb_pipelined_fetch_stage;

    logic        Clk;
    logic        Rst;
    logic        Stall, Flush, BranchTaken, JumpTaken;
    logic [31:0] BranchTarget, JumpTarget;
    logic [31:0] im_addr, im_instr;
    logic [31:0] ifid_instr, ifid_pcplus;
    logic        ifid_valid, align_err;
    logic [15:0] fetch_count;

    logic        z_bit;
    logic [31:0] z_word;
    logic [31:0] im_addr2, im_instr2, ifid_instr2, ifid_pcplus2;
    logic        ifid_valid2, align_err2;
    logic [1:0]  fetch_count2;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_ins, m_pcp;
    logic        m_vld, m_aerr;
    int          m_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_0001;
    endfunction

    assign im_instr  = mem_word(im_addr);
    assign im_instr2 = mem_word(im_addr2);
    assign z_bit     = 1'b0;
    assign z_word    = 32'h0;

    pipelined_fetch_stage dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .JumpTaken(JumpTaken), .JumpTarget(JumpTarget),
        .IM_Address(im_addr), .IM_Instruction(im_instr),
        .IF_ID_Instruction(ifid_instr), .IF_ID_PCPlus(ifid_pcplus),
        .IF_ID_Valid(ifid_valid), .AlignErr(align_err), .FetchCount(fetch_count)
    );

    pipelined_fetch_stage #(.RESET_VECTOR(32'hFFFF_FFF8), .CNT_WIDTH(2)) dut_wrap (
        .Clk(Clk), .Rst(Rst), .Stall(z_bit), .Flush(z_bit),
        .BranchTaken(z_bit), .BranchTarget(z_word),
        .JumpTaken(z_bit), .JumpTarget(z_word),
        .IM_Address(im_addr2), .IM_Instruction(im_instr2),
        .IF_ID_Instruction(ifid_instr2), .IF_ID_PCPlus(ifid_pcplus2),
        .IF_ID_Valid(ifid_valid2), .AlignErr(align_err2), .FetchCount(fetch_count2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ins = 32'h0; m_pcp = 32'h0; m_vld = 1'b0; m_aerr = 1'b0; m_cnt = 0;
    endtask

    task automatic check_all();
        chk("im_addr",     {32'h0, im_addr},     {32'h0, m_pc});
        chk("ifid_instr",  {32'h0, ifid_instr},  {32'h0, m_ins});
        chk("ifid_pcplus", {32'h0, ifid_pcplus}, {32'h0, m_pcp});
        chk("ifid_valid",  {63'h0, ifid_valid},  {63'h0, m_vld});
        chk("align_err",   {63'h0, align_err},   {63'h0, m_aerr});
        chk("fetch_count", {48'h0, fetch_count}, 64'(m_cnt));
    endtask

    // Drive one cycle of controls, advance the model by the fetch rules, then compare after the edge.
    task automatic step(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt);
        logic        red;
        logic [31:0] tgt;
        Stall = st; Flush = fl; BranchTaken = br; BranchTarget = bt; JumpTaken = jp; JumpTarget = jt;
        red = br | jp;
        tgt = br ? bt : jt;
        m_aerr = red && (tgt % 4 != 0);
        if (red || fl) begin
            m_ins = 32'h0; m_pcp = 32'h0; m_vld = 1'b0;
        end else if (!st) begin
            m_ins = mem_word(m_pc); m_pcp = m_pc + 32'd4; m_vld = 1'b1;
            if (m_cnt < 65535) m_cnt++;
        end
        if (red)       m_pc = tgt - (tgt % 4);
        else if (!st)  m_pc = m_pc + 32'd4;
        @(posedge Clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] exp_pc2;
        Rst = 1'b0; Stall = 0; Flush = 0; BranchTaken = 0; JumpTaken = 0;
        BranchTarget = 32'h0; JumpTarget = 32'h0;
        model_reset();

        // Reset held across two edges
        repeat (2) @(posedge Clk);
        #1;
        check_all();
        chk("wrap_reset_pc", {32'h0, im_addr2}, {32'h0, 32'hFFFF_FFF8});
        chk("wrap_reset_cnt", {62'h0, fetch_count2}, 64'h0);
        Rst = 1'b1;

        // Free run; the wrap instance shares the same edges
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 0, 32'h0, 0, 32'h0);
            exp_pc2 = 32'hFFFF_FFF8 + 32'(4 * k);
            chk("wrap_pc", {32'h0, im_addr2}, {32'h0, exp_pc2});
            chk("wrap_cnt", {62'h0, fetch_count2}, 64'((k < 3) ? k : 3));
        end
        chk("run_cnt", {48'h0, fetch_count}, 64'd5);

        // Bring PC back to 0x10 so the fetched word at 0x0C sits in IF/ID, then stall twice
        step(0, 0, 0, 32'h0, 1, 32'h0C);
        step(0, 0, 0, 32'h0, 0, 32'h0);
        chk("pre_stall_pc", {32'h0, im_addr}, 64'h10);
        step(1, 0, 0, 32'h0, 0, 32'h0);
        step(1, 0, 0, 32'h0, 0, 32'h0);
        chk("stall_pc", {32'h0, im_addr}, 64'h10);
        chk("stall_instr", {32'h0, ifid_instr}, {32'h0, mem_word(32'h0C)});
        step(0, 0, 0, 32'h0, 0, 32'h0);
        chk("release_pc", {32'h0, im_addr}, 64'h14);

        // Branch beats jump beats stall
        step(1, 0, 1, 32'h40, 1, 32'h80);
        chk("br_pc", {32'h0, im_addr}, 64'h40);
        chk("br_bubble", {63'h0, ifid_valid}, 64'h0);
        step(0, 0, 0, 32'h0, 0, 32'h0);
        chk("br_pcplus", {32'h0, ifid_pcplus}, 64'h44);
        chk("br_instr", {32'h0, ifid_instr}, {32'h0, mem_word(32'h40)});

        // Misaligned jump pulses AlignErr for one cycle
        step(0, 0, 0, 32'h0, 1, 32'h103);
        chk("mis_pc", {32'h0, im_addr}, 64'h100);
        chk("mis_err", {63'h0, align_err}, 64'h1);
        step(0, 0, 0, 32'h0, 0, 32'h0);
        chk("mis_err_clear", {63'h0, align_err}, 64'h0);

        // Flush under stall: bubble in IF/ID, PC holds
        step(1, 1, 0, 32'h0, 0, 32'h0);
        chk("flush_stall_pc", {32'h0, im_addr}, 64'h104);

        // Randomized controls and targets, including misaligned ones
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, 32'($urandom_range(0, 16'hFFFF)),
                 $urandom_range(0, 7) == 0, 32'($urandom_range(0, 16'hFFFF)));
        end

        // Asynchronous reset between edges at PC=0x24
        step(0, 0, 0, 32'h0, 1, 32'h20);
        step(0, 0, 0, 32'h0, 0, 32'h0);
        chk("pre_areset_pc", {32'h0, im_addr}, 64'h24);
        #2;
        Rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("areset_wrap_pc", {32'h0, im_addr2}, {32'h0, 32'hFFFF_FFF8});
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        step(0, 0, 0, 32'h0, 0, 32'h0);
        step(0, 0, 0, 32'h0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
